dmem_responder: RTL and testbench

Data-memory responder for the CPU's data bus, the slave end of the memwrite / dataadr / writedata interface the processor drives. It accepts a single request per transaction, inserts a programmable number of wait states, then performs the word write or read against an internal word-addressed RAM. It answers with a one-cycle `ready` pulse, read data and an error flag. It sits between the datapath's memory stage and storage, and is the target the multi-cycle and pipelined CPU builds stall against.

---
 rtl/dmem_responder.sv | 73 +++++++
 tb/tb_dmem_responder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word RAM slave for the CPU data bus; define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses
module dmem_responder #(
    parameter int ADDR_W  = 6,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreq,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    state_t state, next;
    logic [3:0] cnt;
    logic wr_q;
    logic [ADDR_W-1:0] idx_q;
    logic [31:0] wd_q;
    logic [31:0] mem [2**ADDR_W];
    logic mis;
    logic accept;
    assign accept = state == IDLE && memreq;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
        end else begin
            state <= next;
            if (accept) cnt <= LAT_M1;
            else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q <= memwrite;
            idx_q <= dataadr[ADDR_W+1:2];
            wd_q <= writedata;
        end
    end
    always_comb begin
        next = state;
        unique case (state)
            IDLE: if (memreq) next = LATENCY > 0 ? WAIT : RESP;
            WAIT: if (cnt == 4'd0) next = RESP;
            RESP: next = IDLE;
            default: next = IDLE;
        endcase
    end
`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lo_q;
    logic unused_adr;
    always_ff @(posedge clk) if (accept) lo_q <= dataadr[1:0];
    assign mis = |lo_q;
    assign unused_adr = ^dataadr[31:ADDR_W+2];
`else
    logic unused_adr;
    assign mis = 1'b0;
    assign unused_adr = ^{dataadr[31:ADDR_W+2], dataadr[1:0]};
`endif
    assign ready = state == RESP;
    assign busy = state != IDLE;
    assign err = ready && mis;
    assign readdata = (ready && !mis) ? mem[idx_q] : '0;
    // a reset landing on the closing edge of RESP still discards the write
    always_ff @(posedge clk) begin
        if (!rst && ready && wr_q && !mis) mem[idx_q] <= wd_q;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed checks of a LATENCY=2 and a LATENCY=0 responder
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic memreq_a = 1'b0, memreq_b = 1'b0, memwrite = 1'b0;
    logic [31:0] dataadr = '0, writedata = '0;
    logic [31:0] readdata_a, readdata_b;
    logic ready_a, ready_b, busy_a, busy_b, err_a, err_b;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(6), .LATENCY(2)) u_a (
        .clk(clk), .rst(rst), .memreq(memreq_a), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .readdata(readdata_a),
        .ready(ready_a), .busy(busy_a), .err(err_a));

    dmem_responder #(.ADDR_W(6), .LATENCY(0)) u_b (
        .clk(clk), .rst(rst), .memreq(memreq_b), .memwrite(memwrite),
        .dataadr(dataadr), .writedata(writedata), .readdata(readdata_b),
        .ready(ready_b), .busy(busy_b), .err(err_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one transaction; lat = cycles from accepting edge to the ready cycle, -1 on timeout
    task automatic txn(input bit b, input bit wr, input logic [31:0] adr, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat, output int bsy);
        bit done = 0;
        @(negedge clk);
        memwrite = wr; dataadr = adr; writedata = wd;
        if (b) memreq_b = 1'b1; else memreq_a = 1'b1;
        @(posedge clk);
        #1 memreq_a = 1'b0; memreq_b = 1'b0;
        lat = 0; bsy = 0; rd = 'x; e = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            lat++;
            if (b ? busy_b : busy_a) bsy++;
            if (b ? ready_b : ready_a) begin
                rd = b ? readdata_b : readdata_a;
                e = b ? err_b : err_a;
                done = 1;
            end
        end
        if (!done) lat = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic e;
        int lat, bsy, nrdy;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_err", 32'(err_a), 0);
        chk("rst_readdata", readdata_a, 0);
        rst = 1'b0;

        txn(0, 1, 84, 7, rd, e, lat, bsy);
        chk("w84_latency", 32'(lat), 3);
        chk("w84_busy_cycles", 32'(bsy), 3);
        chk("w84_err", 32'(e), 0);
        @(negedge clk);
        chk("w84_ready_single", 32'(ready_a), 0);
        chk("w84_busy_fall", 32'(busy_a), 0);
        chk("idle_readdata", readdata_a, 0);

        txn(0, 1, 80, 5, rd, e, lat, bsy);
        txn(0, 0, 84, 0, rd, e, lat, bsy);
        chk("r84_data", rd, 7);
        chk("r84_latency", 32'(lat), 3);
        txn(0, 0, 80, 0, rd, e, lat, bsy);
        chk("r80_data", rd, 5);
        txn(0, 1, 84, 32'h11, rd, e, lat, bsy);
        chk("w84_old_word", rd, 7);
        txn(0, 0, 84, 0, rd, e, lat, bsy);
        chk("b2b_r84_new", rd, 32'h11);

        txn(1, 1, 0, 32'hDEADBEEF, rd, e, lat, bsy);
        chk("l0_w_latency", 32'(lat), 1);
        txn(1, 0, 0, 0, rd, e, lat, bsy);
        chk("l0_r_latency", 32'(lat), 1);
        chk("l0_r_busy", 32'(bsy), 1);
        chk("l0_r_data", rd, 32'hDEADBEEF);

        txn(0, 1, 0, 32'hA0, rd, e, lat, bsy);
        txn(0, 1, 4, 32'hB0, rd, e, lat, bsy);
        // continuous requests: only the IDLE-cycle ones (always address 0) are taken
        nrdy = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (ready_a) nrdy++;
            memreq_a = 1'b1; memwrite = 1'b1;
            dataadr = (k % 2 == 0) ? 32'd0 : 32'd4;
            writedata = 32'h100 + 32'(k);
        end
        @(negedge clk);
        memreq_a = 1'b0;
        chk("hold_ready_count", 32'(nrdy), 3);
        txn(0, 0, 0, 0, rd, e, lat, bsy);
        chk("hold_r0", rd, 32'h108);
        txn(0, 0, 4, 0, rd, e, lat, bsy);
        chk("hold_r4_unchanged", rd, 32'hB0);

        txn(0, 1, 256, 9, rd, e, lat, bsy);
        txn(0, 0, 0, 0, rd, e, lat, bsy);
        chk("wrap_r0", rd, 9);
        txn(0, 0, 32'h1000_0054, 0, rd, e, lat, bsy);
        chk("wrap_upper_bits", rd, 32'h11);

        txn(0, 1, 86, 1, rd, e, lat, bsy);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("mis_w_err", 32'(e), 1);
        txn(0, 0, 84, 0, rd, e, lat, bsy);
        chk("mis_r84_unchanged", rd, 32'h11);
        txn(0, 0, 86, 0, rd, e, lat, bsy);
        chk("mis_r_err", 32'(e), 1);
        chk("mis_r_data", rd, 0);
`else
        chk("mis_w_err", 32'(e), 0);
        txn(0, 0, 84, 0, rd, e, lat, bsy);
        chk("mis_r84_word", rd, 1);
        txn(0, 0, 87, 0, rd, e, lat, bsy);
        chk("mis_r87_err", 32'(e), 0);
`endif

        txn(0, 1, 20, 32'h33, rd, e, lat, bsy);
        @(negedge clk);
        memwrite = 1'b1; dataadr = 20; writedata = 32'h77; memreq_a = 1'b1;
        @(posedge clk);
        #1 memreq_a = 1'b0;
        @(negedge clk);
        chk("abort_busy_wait", 32'(busy_a), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(ready_a), 0);
        chk("abort_busy", 32'(busy_a), 0);
        chk("abort_err", 32'(err_a), 0);
        chk("abort_readdata", readdata_a, 0);
        rst = 1'b0;
        nrdy = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ready_a) nrdy++;
        end
        chk("abort_no_ready", 32'(nrdy), 0);
        txn(0, 0, 20, 0, rd, e, lat, bsy);
        chk("abort_ram_kept", rd, 32'h33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
